// File: rtl/alert_esc_pkg.sv
// Shared types and width defaults for the alert class escalation controller.
package alert_esc_pkg;

  localparam int ACCU_CNT_DW = 16;
  localparam int ESC_CNT_DW  = 32;
  localparam int N_ESC_SEV   = 4;
  localparam int N_PHASES    = 4;
  localparam int PHASE_DW    = 2;

  // Phase states carry their phase index in the low bits.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_TIMEOUT  = 3'b001,
    ST_TERMINAL = 3'b011,
    ST_PHASE0   = 3'b100,
    ST_PHASE1   = 3'b101,
    ST_PHASE2   = 3'b110,
    ST_PHASE3   = 3'b111
  } esc_state_e;

  function automatic esc_state_e next_phase(esc_state_e s);
    case (s)
      ST_PHASE0: return ST_PHASE1;
      ST_PHASE1: return ST_PHASE2;
      ST_PHASE2: return ST_PHASE3;
      default:   return ST_TERMINAL;
    endcase
  endfunction

endpackage

// File: rtl/alert_esc_accu.sv
// Saturating alert accumulator with threshold compare against the pre-increment count.
module alert_esc_accu
  import alert_esc_pkg::*;
#(
  parameter int AccuCntDw = ACCU_CNT_DW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trig_i,
  input  logic                 clr_i,
  input  logic [AccuCntDw-1:0] thresh_i,
  output logic [AccuCntDw-1:0] accu_cnt_o,
  output logic                 accu_esc_o
);

  logic [AccuCntDw-1:0] accu_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)
      accu_q <= '0;
    else if (trig_i && (accu_q != '1))
      accu_q <= accu_q + AccuCntDw'(1);
  end

  assign accu_cnt_o = accu_q;
  assign accu_esc_o = trig_i && (accu_q >= thresh_i);

endmodule

// File: rtl/alert_class_esc_ctrl.sv
// Per-class escalation FSM: accumulate, optional timeout, four timed phases, terminal.
// Optional feature: define ALERT_ESC_TIMEOUT_EN to build the Timeout state.
module alert_class_esc_ctrl #(
  parameter int AccuCntDw = alert_esc_pkg::ACCU_CNT_DW,
  parameter int EscCntDw  = alert_esc_pkg::ESC_CNT_DW,
  parameter int N_ESC_SEV = alert_esc_pkg::N_ESC_SEV,
  parameter int N_PHASES  = alert_esc_pkg::N_PHASES,
  parameter int PHASE_DW  = alert_esc_pkg::PHASE_DW
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          class_trig_i,
  input  logic                          clr_i,
  input  logic                          clr_lock_i,
  input  logic [AccuCntDw-1:0]          accu_thresh_i,
  input  logic [EscCntDw-1:0]           timeout_cyc_i,
  input  logic [N_PHASES*EscCntDw-1:0]  phase_cyc_i,
  input  logic [N_ESC_SEV-1:0]          esc_en_i,
  input  logic [N_ESC_SEV*PHASE_DW-1:0] esc_map_i,
  output logic [AccuCntDw-1:0]          accu_cnt_o,
  output logic [EscCntDw-1:0]           esc_cnt_o,
  output logic [2:0]                    esc_state_o,
  output logic [N_ESC_SEV-1:0]          esc_sig_o,
  output logic                          esc_trig_o
);
  import alert_esc_pkg::*;

  esc_state_e state_q, state_d;
  logic [EscCntDw-1:0] esc_cnt_q, esc_cnt_d;
  logic [EscCntDw:0]   cnt_inc;
  logic [N_PHASES-1:0][EscCntDw-1:0] phase_cyc_arr;
  logic [EscCntDw-1:0] phase_cyc;
  logic esc_trig_q, trig_vld, locked, clr_eff, accu_esc;

  assign trig_vld = class_trig_i & en_i;
  // Once escalation has started, the lock protects it from software clears.
  assign locked   = clr_lock_i & (state_q[2] | (state_q == ST_TERMINAL));
  assign clr_eff  = clr_i & ~locked;

  alert_esc_accu #(.AccuCntDw(AccuCntDw)) u_accu (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .trig_i     (trig_vld),
    .clr_i      (clr_eff),
    .thresh_i   (accu_thresh_i),
    .accu_cnt_o (accu_cnt_o),
    .accu_esc_o (accu_esc)
  );

  assign cnt_inc       = {1'b0, esc_cnt_q} + (EscCntDw+1)'(1);
  assign phase_cyc_arr = phase_cyc_i;
  assign phase_cyc     = phase_cyc_arr[state_q[PHASE_DW-1:0]];

`ifndef ALERT_ESC_TIMEOUT_EN
  logic timeout_unused;
  assign timeout_unused = ^timeout_cyc_i;
`endif

  always_comb begin
    state_d   = state_q;
    esc_cnt_d = esc_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accu_esc) state_d = ST_PHASE0;
`ifdef ALERT_ESC_TIMEOUT_EN
        else if (trig_vld && (timeout_cyc_i != '0)) state_d = ST_TIMEOUT;
`endif
      end
`ifdef ALERT_ESC_TIMEOUT_EN
      ST_TIMEOUT: begin
        if (!en_i)                                            state_d = ST_IDLE;
        else if (accu_esc || (cnt_inc >= {1'b0, timeout_cyc_i})) state_d = ST_PHASE0;
        else                                                  esc_cnt_d = cnt_inc[EscCntDw-1:0];
      end
`endif
      ST_PHASE0, ST_PHASE1, ST_PHASE2, ST_PHASE3: begin
        if (cnt_inc >= {1'b0, phase_cyc}) state_d = next_phase(state_q);
        else                              esc_cnt_d = cnt_inc[EscCntDw-1:0];
      end
      ST_TERMINAL: ;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) esc_cnt_d = '0;
    // Clear beats any simultaneous trigger or phase advance.
    if (clr_eff) begin
      state_d   = ST_IDLE;
      esc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      esc_cnt_q  <= '0;
      esc_trig_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      esc_cnt_q  <= esc_cnt_d;
      esc_trig_q <= (state_d == ST_PHASE0) && (state_q != ST_PHASE0);
    end
  end

  for (genvar s = 0; s < N_ESC_SEV; s++) begin : g_sig
    assign esc_sig_o[s] = esc_en_i[s] & state_q[2] &
                          (state_q[PHASE_DW-1:0] == esc_map_i[s*PHASE_DW +: PHASE_DW]);
  end

  assign esc_state_o = state_q;
  assign esc_cnt_o   = esc_cnt_q;
  assign esc_trig_o  = esc_trig_q;

endmodule
